// File: rtl/exec_dispatch_pkg.sv
// Shared definitions for the command dispatcher.
//   state_t  : dispatcher FSM states (2-bit encoding)
//   ERR_*    : sticky error codes reported on error_code
package exec_dispatch_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    ISSUE   = S_ISSUE,
    WAIT    = S_WAIT,
    RELEASE = S_RELEASE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_TGT = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

endpackage

// File: rtl/dispatch_watchdog.sv
// Cycle counter that bounds the time an executor may spend on one command.
// Only present when DISPATCH_TIMEOUT_EN is defined.
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   clear    in   restart the count at 0 on the next cycle
//   run      in   count while high
//   expired  out  high while running and the count is TIMEOUT_CYCLES-1
`ifdef DISPATCH_TIMEOUT_EN
module dispatch_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/exec_dispatcher.sv
// Command scheduler between the ring buffer read side and the executors.
// Captures one command per sample_command pulse, routes it to the executor
// selected by command[TGT_LSB +: TGT_W], waits for that executor's done and
// then pulses next_instruction. One command in flight at a time.
// Optional feature: DISPATCH_TIMEOUT_EN adds a watchdog that aborts WAIT.
//   clock, reset       system clock, synchronous active-high reset
//   sample_command     1-cycle pulse, command valid
//   command            command word from the ring buffer
//   next_instruction   1-cycle pulse, ring buffer may advance
//   exec_sample        one-hot 1-cycle pulse to the selected executor
//   exec_command       captured command, held until the next capture
//   exec_done          per-executor completion pulses
//   busy               high outside IDLE
//   active_target      target field of the command in flight
//   error_code         sticky, most recent error wins
//
// state   | meaning
// IDLE    | waiting for sample_command
// ISSUE   | pulse exec_sample to the target executor
// WAIT    | waiting for the target's exec_done (or watchdog expiry)
// RELEASE | pulse next_instruction
module exec_dispatcher
  import exec_dispatch_pkg::*;
#(
  parameter int NUM_EXEC       = 2,
  parameter int DATA_W         = 32,
  parameter int TGT_LSB        = 28,
  parameter int TGT_W          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_command,
  input  logic [DATA_W-1:0]   command,
  output logic                next_instruction,
  output logic [NUM_EXEC-1:0] exec_sample,
  output logic [DATA_W-1:0]   exec_command,
  input  logic [NUM_EXEC-1:0] exec_done,
  output logic                busy,
  output logic [TGT_W-1:0]    active_target,
  output logic [1:0]          error_code
);

  state_t               state, state_nxt;
  logic [TGT_W-1:0]     cmd_tgt;
  logic                 tgt_ok;
  logic [NUM_EXEC-1:0]  tgt_onehot;
  logic                 done_sel;
  logic                 wd_expired;

  assign cmd_tgt = command[TGT_LSB +: TGT_W];
  // full-width compare so out-of-range targets never alias onto a real executor
  assign tgt_ok  = (32'(cmd_tgt) < 32'(NUM_EXEC));

  always_comb begin
    tgt_onehot = '0;
    for (int i = 0; i < NUM_EXEC; i++) begin
      tgt_onehot[i] = (32'(active_target) == 32'(i));
    end
  end

  assign done_sel = |(exec_done & tgt_onehot);

`ifdef DISPATCH_TIMEOUT_EN
  dispatch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ISSUE),
    .run     (state == WAIT),
    .expired (wd_expired)
  );
`else
  // no watchdog: WAIT ends only on done; the parameter is kept so both
  // builds share one instantiation
  localparam bit TIMEOUT_ARMED = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign wd_expired = TIMEOUT_ARMED;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      exec_command  <= '0;
      active_target <= '0;
      error_code    <= ERR_NONE;
    end else begin
      state <= state_nxt;
      if (state == IDLE && sample_command) begin
        exec_command  <= command;
        active_target <= cmd_tgt;
        if (!tgt_ok) begin
          error_code <= ERR_BAD_TGT;
        end
      end
      // done in the expiry cycle wins: no timeout error then
      if (state == WAIT && wd_expired && !done_sel) begin
        error_code <= ERR_TIMEOUT;
      end
      if (state != IDLE && sample_command) begin
        error_code <= ERR_OVERRUN;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    busy             = 1'b1;
    next_instruction = 1'b0;
    exec_sample      = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (sample_command) begin
          state_nxt = tgt_ok ? ISSUE : RELEASE;
        end
      end
      ISSUE: begin
        exec_sample = tgt_onehot;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (done_sel || wd_expired) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        next_instruction = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_dispatcher.sv
module tb_exec_dispatcher;

  localparam int NUM_EXEC = 2;
  localparam int DATA_W   = 32;
  localparam int TGT_LSB  = 28;
  localparam int TGT_W    = 4;
  localparam int TO       = 16;
`ifdef DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                sample_command;
  logic [DATA_W-1:0]   command;
  logic                next_instruction;
  logic [NUM_EXEC-1:0] exec_sample;
  logic [DATA_W-1:0]   exec_command;
  logic [NUM_EXEC-1:0] exec_done;
  logic                busy;
  logic [TGT_W-1:0]    active_target;
  logic [1:0]          error_code;

  always #5 clock = ~clock;

  exec_dispatcher #(
    .NUM_EXEC       (NUM_EXEC),
    .DATA_W         (DATA_W),
    .TGT_LSB        (TGT_LSB),
    .TGT_W          (TGT_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .sample_command   (sample_command),
    .command          (command),
    .next_instruction (next_instruction),
    .exec_sample      (exec_sample),
    .exec_command     (exec_command),
    .exec_done        (exec_done),
    .busy             (busy),
    .active_target    (active_target),
    .error_code       (error_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: timestamps of the command in flight, in clock edges.
  // iss_edge: edge after which exec_sample is shown; rel_edge: edge after
  // which next_instruction is shown (-1 = not yet known).
  int          cyc = 0;
  bit          m_active, m_busy;
  int          iss_edge, rel_edge;
  logic [31:0] m_cmd;
  logic [3:0]  m_tgt;
  logic [1:0]  m_err;
  int          ni_seen = 0;

  task automatic step(input bit r, input bit s, input logic [31:0] c, input logic [1:0] d);
    logic [1:0] exp_sample;
    bit         exp_ni;
    reset          = r;
    sample_command = s;
    command        = c;
    exec_done      = d;
    @(posedge clock);
    cyc++;
    if (r) begin
      m_active = 1'b0; m_cmd = '0; m_tgt = '0; m_err = 2'b00;
      iss_edge = -1;   rel_edge = -1;
    end else if (!m_busy) begin
      m_active = 1'b0;
      if (s) begin
        m_active = 1'b1;
        m_cmd    = c;
        m_tgt    = c[31:28];
        if (int'(m_tgt) < NUM_EXEC) begin
          iss_edge = cyc; rel_edge = -1;
        end else begin
          iss_edge = -1;  rel_edge = cyc; m_err = 2'b01;
        end
      end
    end else begin
      // executor is waiting from two edges after issue until release
      if (iss_edge >= 0 && rel_edge < 0 && cyc >= iss_edge + 2) begin
        if (d[m_tgt[0]]) begin
          rel_edge = cyc;
        end else if (TO_EN && cyc == iss_edge + TO + 1) begin
          rel_edge = cyc; m_err = 2'b10;
        end
      end
      if (s) m_err = 2'b11;
    end
    m_busy     = m_active && (rel_edge < 0 || cyc <= rel_edge);
    exp_sample = (m_active && iss_edge == cyc) ? (2'b01 << m_tgt[0]) : 2'b00;
    exp_ni     = m_active && rel_edge == cyc;
    #1;
    check_eq("exec_sample",      32'(exec_sample),      32'(exp_sample));
    check_eq("next_instruction", 32'(next_instruction), 32'(exp_ni));
    check_eq("busy",             32'(busy),             32'(m_busy));
    check_eq("exec_command",     exec_command,          m_cmd);
    check_eq("active_target",    32'(active_target),    32'(m_tgt));
    check_eq("error_code",       32'(error_code),       32'(m_err));
    ni_seen += int'(next_instruction);
    reset = 1'b0; sample_command = 1'b0; exec_done = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, command, 2'b00);
  endtask

  initial begin
    int         ni0;
    bit         r, s;
    logic [3:0] tgt;
    logic [1:0] d;
    reset = 1'b1; sample_command = 1'b0; command = '0; exec_done = '0;
    m_active = 1'b0; m_busy = 1'b0; iss_edge = -1; rel_edge = -1;
    m_cmd = '0; m_tgt = '0; m_err = 2'b00;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 2'b00);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_err",  32'(error_code), 32'h0);

    // good command to exec 1, done after 5 cycles
    step(1'b0, 1'b1, 32'h1000_00AA, 2'b00);
    check_eq("t1_sample", 32'(exec_sample), 32'h2);
    idle(5);
    step(1'b0, 1'b0, command, 2'b10);
    check_eq("t1_ni",  32'(next_instruction), 32'h1);
    check_eq("t1_err", 32'(error_code), 32'h0);
    idle(2);

    // bad target
    step(1'b0, 1'b1, 32'h7000_0001, 2'b00);
    check_eq("t2_ni",     32'(next_instruction), 32'h1);
    check_eq("t2_sample", 32'(exec_sample), 32'h0);
    check_eq("t2_err",    32'(error_code), 32'h1);
    idle(2);

    // overrun during WAIT
    ni0 = ni_seen;
    step(1'b0, 1'b1, 32'h0000_0005, 2'b00);
    idle(2);
    step(1'b0, 1'b1, 32'h1234_5678, 2'b00);
    check_eq("t3_err", 32'(error_code), 32'h3);
    check_eq("t3_cmd", exec_command, 32'h0000_0005);
    step(1'b0, 1'b0, command, 2'b01);
    idle(4);
    check_eq("t3_ni_count", 32'(ni_seen - ni0), 32'h1);

    // done from the wrong executor is ignored
    step(1'b1, 1'b0, 32'h0, 2'b00);
    step(1'b0, 1'b1, 32'h0000_0000, 2'b00);
    idle(2);
    step(1'b0, 1'b0, command, 2'b10);
    check_eq("t5_busy", 32'(busy), 32'h1);
    check_eq("t5_ni",   32'(next_instruction), 32'h0);
    idle(1);
    step(1'b0, 1'b0, command, 2'b01);
    check_eq("t5_done", 32'(next_instruction), 32'h1);
    idle(2);

`ifdef DISPATCH_TIMEOUT_EN
    // executor 0 never answers
    step(1'b1, 1'b0, 32'h0, 2'b00);
    ni0 = ni_seen;
    step(1'b0, 1'b1, 32'h0000_0042, 2'b00);
    idle(16);
    check_eq("t4_ni_early", 32'(ni_seen - ni0), 32'h0);
    idle(1);
    check_eq("t4_ni",  32'(next_instruction), 32'h1);
    check_eq("t4_err", 32'(error_code), 32'h2);
    step(1'b0, 1'b0, command, 2'b01);
    step(1'b0, 1'b0, command, 2'b01);
    check_eq("t4_late_busy", 32'(busy), 32'h0);
    check_eq("t4_ni_count",  32'(ni_seen - ni0), 32'h1);
`endif

    // reset during WAIT
    step(1'b0, 1'b1, 32'h1000_0009, 2'b00);
    idle(2);
    ni0 = ni_seen;
    step(1'b1, 1'b0, command, 2'b00);
    check_eq("t6_busy", 32'(busy), 32'h0);
    check_eq("t6_cmd",  exec_command, 32'h0);
    check_eq("t6_err",  32'(error_code), 32'h0);
    check_eq("t6_ni",   32'(ni_seen - ni0), 32'h0);
    step(1'b0, 1'b1, 32'h1000_0003, 2'b00);
    check_eq("t6_sample", 32'(exec_sample), 32'h2);
    idle(2);
    step(1'b0, 1'b0, command, 2'b10);
    check_eq("t6_done", 32'(next_instruction), 32'h1);
    idle(2);

    // randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      r   = ($urandom_range(0, 299) == 0);
      s   = m_busy ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
      tgt = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      d   = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      step(r, s, {tgt, 28'($urandom)}, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1);
  end

endmodule
